// File: rtl/avg_accel.sv
// avg_accel: mean of N big-endian 8.8 values read from data memory, written back as floor(sum/N).
module avg_accel #(
  parameter int ADDR_W = 10,
  parameter int SUM_W = 24
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [7:0]        MemDataOut,
  input  logic [7:0]        MemDataIn
);
  localparam int CW = $clog2(SUM_W);
  typedef enum logic [3:0] {IDLE, ARM, RD_N, RD_HI, RD_LO, DIV, WR_HI, WR_LO, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] n_q, n_d, hi_q, hi_d, rem_q, rem_d, dout_q, dout_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0] rem_s, rem_n;
  logic ge, ack_q, ack_d, rd_q, rd_d, wr_q, wr_d;
  // The address register doubles as the operand pointer; after the reads it sits at 2N+1.
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    hi_d = hi_q;
    sum_d = sum_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    rem_s = {rem_q, sum_q[SUM_W-1]};
    ge = rem_s >= {1'b0, n_q};
    rem_n = ge ? rem_s - {1'b0, n_q} : rem_s;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        state_d = Start ? ARM : IDLE;
      end
      ARM: begin
        addr_d = '0;
        state_d = Start ? ARM : RD_N;
      end
      RD_N: begin
        n_d = MemDataIn;
        sum_d = '0;
        rem_d = '0;
        cnt_d = '0;
        addr_d = addr_q + 1'b1;
        state_d = (MemDataIn == 8'd0) ? WR_HI : RD_HI;
      end
      RD_HI: begin
        hi_d = MemDataIn;
        addr_d = addr_q + 1'b1;
        state_d = RD_LO;
      end
      RD_LO: begin
        sum_d = sum_q + SUM_W'({hi_q, MemDataIn});
        addr_d = addr_q + 1'b1;
        state_d = (addr_q == ADDR_W'({n_q, 1'b0})) ? DIV : RD_HI;
      end
      DIV: begin
        sum_d = {sum_q[SUM_W-2:0], ge};
        rem_d = rem_n[7:0];
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SUM_W - 1)) ? WR_HI : DIV;
      end
      WR_HI: begin
        addr_d = addr_q + 1'b1;
        state_d = WR_LO;
      end
      WR_LO: state_d = DONE;
      DONE: state_d = Start ? ARM : DONE;
      default: state_d = IDLE;
    endcase
    // Strobes and write data are registered alongside the state they belong to.
    rd_d = state_d inside {RD_N, RD_HI, RD_LO};
    wr_d = state_d inside {WR_HI, WR_LO};
    dout_d = (state_d == WR_HI) ? sum_d[15:8] : (state_d == WR_LO) ? sum_d[7:0] : 8'd0;
    ack_d = (state_q == DONE) && !Start;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      n_q <= '0;
      hi_q <= '0;
      sum_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      dout_q <= '0;
      ack_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      hi_q <= hi_d;
      sum_q <= sum_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      ack_q <= ack_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  assign Ack = ack_q;
  assign MemAddr = addr_q;
  assign MemRead = rd_q;
  assign MemWrite = wr_q;
  assign MemDataOut = dout_q;
endmodule
